hazard_controller: RTL and testbench

- Pipeline hazard sequencer for the 5-stage RV32 core. Sits beside the forwarding logic and owns every hazard that forwarding cannot resolve.
- Inserts the single load-use bubble and flushes D/E on a taken branch.
- Sequences the multi-cycle execute unit (mul/div) with a start/done handshake, freezing F/D/E and bubbling M while the unit is busy. A timeout guards against a lost done.

---
 rtl/hazard_controller.sv | 162 ++++++++++++++++
 tb/tb_hazard_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard sequencer for the 5-stage RV32 core. Handles the hazards
//   that forwarding cannot resolve. A load-use hazard inserts one bubble, and
//   a taken branch flushes D/E. A multi-cycle execute op (mul/div) is
//   sequenced with a start/done handshake and guarded by a timeout.
//
// Parameters
//   MC_TIMEOUT : max cycles spent in MC_WAIT before forced release (>= 2)
//   CNT_W      : width of the performance counters (HAZARD_PERF_CNT_EN only)
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When it is defined, the stall_cnt and flush_cnt outputs are added. They
//   are saturating counts of the cycles with stall_F=1 and with flush_D=1.
//
// Ports
//   clk, reset                 core clock, synchronous active-low reset
//   mem_read_E, rd_E           load in E and its destination register
//   rs1_D, rs2_D               sources of the instruction in D
//   use_rs1_D, use_rs2_D       D really reads rs1 / rs2
//   branch_taken_E             taken branch/jump resolved in E
//   mc_op_E, mc_done           multi-cycle op in E / unit result pulse
//   stall_F/D/E                hold PC, IF/ID, ID/EX
//   flush_D/E/M                clear IF/ID, ID/EX, EX/MEM to NOP
//   mc_start                   one-cycle start pulse to the multi-cycle unit
//   mc_err                     sticky multi-cycle timeout flag
module hazard_controller #(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_read_E,
  input  logic [4:0] rd_E,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic       use_rs1_D,
  input  logic       use_rs2_D,
  input  logic       branch_taken_E,
  input  logic       mc_op_E,
  input  logic       mc_done,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_M,
  output logic       mc_start,
  output logic       mc_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST_CNT = TW'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MC_WAIT, MC_RELEASE} state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_cnt, w_cnt_next;
  logic          r_err, w_err_set;
  logic          w_load_use;

  assign w_load_use = mem_read_E && (rd_E != '0) &&
                      ((use_rs1_D && (rs1_D == rd_E)) ||
                       (use_rs2_D && (rs2_D == rd_E)));

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_err_set  = 1'b0;
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    stall_E    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    flush_M    = 1'b0;
    mc_start   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (mc_op_E) begin
          mc_start   = 1'b1;
          stall_F    = 1'b1;
          stall_D    = 1'b1;
          stall_E    = 1'b1;
          flush_M    = 1'b1;
          w_cnt_next = '0;
          w_next     = MC_WAIT;
        end else if (branch_taken_E) begin
          flush_D = 1'b1;
          flush_E = 1'b1;
        end else if (w_load_use) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end
      end
      MC_WAIT: begin
        stall_F    = 1'b1;
        stall_D    = 1'b1;
        stall_E    = 1'b1;
        flush_M    = 1'b1;
        w_cnt_next = r_cnt + TW'(1);
        // A done that arrives on the timeout cycle wins, and no error is set.
        if (mc_done) begin
          w_next = MC_RELEASE;
        end else if (r_cnt == LAST_CNT) begin
          w_err_set = 1'b1;
          w_next    = MC_RELEASE;
        end
      end
      MC_RELEASE: begin
        // E still holds the finished mc op, so every E/D hazard is ignored.
        w_next = RUN;
      end
      default: w_next = RUN;
    endcase
    mc_err = r_err;
    if (!reset) begin
      stall_F  = 1'b0;
      stall_D  = 1'b0;
      stall_E  = 1'b0;
      flush_D  = 1'b0;
      flush_E  = 1'b0;
      flush_M  = 1'b0;
      mc_start = 1'b0;
      mc_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_err_set) r_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_F && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_D && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller built with MC_TIMEOUT=8 and
// CNT_W=2. A stimulus process drives one vector per cycle and queues the
// expected output vector for that cycle. A monitor samples on the falling
// edge and pops and compares each entry.
// Expected vector order: {stall_F, stall_D, stall_E, flush_D, flush_E,
// flush_M, mc_start, mc_err}.
module tb_hazard_controller;

  logic       clk;
  logic       reset;
  logic       mem_read_E;
  logic [4:0] rd_E, rs1_D, rs2_D;
  logic       use_rs1_D, use_rs2_D, branch_taken_E, mc_op_E, mc_done;
  logic       stall_F, stall_D, stall_E, flush_D, flush_E, flush_M;
  logic       mc_start, mc_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [1:0] stall_cnt, flush_cnt;
`endif

  hazard_controller #(.MC_TIMEOUT(8), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .mem_read_E(mem_read_E), .rd_E(rd_E), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .branch_taken_E(branch_taken_E), .mc_op_E(mc_op_E), .mc_done(mc_done),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .mc_start(mc_start), .mc_err(mc_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  localparam logic [7:0] E_IDLE  = 8'b0000_0000;
  localparam logic [7:0] E_LU    = 8'b1100_1000;
  localparam logic [7:0] E_BR    = 8'b0001_1000;
  localparam logic [7:0] E_START = 8'b1110_0110;
  localparam logic [7:0] E_WAIT  = 8'b1110_0100;
  localparam logic [7:0] E_ERR   = 8'b0000_0001;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the outputs
  // expected for that cycle.
  task automatic step(input logic rst, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic br,
                      input logic mc, input logic dn,
                      input logic [7:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; mem_read_E = mr; rd_E = rd; rs1_D = r1; rs2_D = r2;
    use_rs1_D = u1; use_rs2_D = u2; branch_taken_E = br;
    mc_op_E = mc; mc_done = dn;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [7:0] exp, input string name);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp, name);
  endtask

  task automatic mc(input logic dn, input logic [7:0] exp, input string name);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, dn, exp, name);
  endtask

  // Monitor: every cycle that has a queued expectation, compare it.
  initial begin
    exp_t e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mc_start, mc_err};
        n_checks++;
        if (got !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; mem_read_E = 0; rd_E = 0; rs1_D = 0; rs2_D = 0;
    use_rs1_D = 0; use_rs2_D = 0; branch_taken_E = 0; mc_op_E = 0; mc_done = 0;

    // Reset held with mc op and load-use present: everything stays quiet.
    repeat (3) step(0, 1, 5, 5, 5, 1, 1, 0, 1, 0, E_IDLE, "reset");

    // mc op: start, 4 wait cycles (done on the 4th), release, run.
    mc(0, E_START, "mc_start");
    repeat (3) mc(0, E_WAIT, "mc_wait");
    mc(1, E_WAIT, "mc_wait_done");
    step(1, 1, 5, 5, 5, 1, 1, 1, 1, 0, E_IDLE, "mc_release_ignores");
    idle(E_IDLE, "run_idle");

    // Load-use detection.
    step(1, 1, 5, 0, 5, 0, 1, 0, 0, 0, E_LU,   "lu_rs2");
    step(1, 0, 5, 0, 5, 0, 1, 0, 0, 0, E_IDLE, "lu_one_bubble");
    step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, E_IDLE, "lu_rd0");
    step(1, 1, 7, 7, 0, 1, 0, 0, 0, 0, E_LU,   "lu_rs1");
    step(1, 1, 7, 7, 7, 0, 0, 0, 0, 0, E_IDLE, "lu_no_use");
    step(1, 0, 7, 7, 7, 1, 1, 0, 0, 0, E_IDLE, "no_load");

    // Branch beats load-use; done in RUN is ignored.
    step(1, 1, 5, 5, 5, 1, 1, 1, 0, 0, E_BR,   "br_over_lu");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_IDLE, "done_in_run");

    // mc op beats branch, then a back-to-back mc op.
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_START, "mc_over_br");
    mc(1, E_WAIT, "wait_done_first");
    step(1, 1, 3, 3, 3, 1, 1, 1, 1, 0, E_IDLE, "release2");
    mc(0, E_START, "b2b_start");
    mc(1, E_WAIT, "b2b_wait_done");
    mc(0, E_IDLE, "b2b_release");
    idle(E_IDLE, "b2b_run");

    // Timeout: 8 wait cycles, no done -> release with sticky error.
    mc(0, E_START, "to_start");
    repeat (8) mc(0, E_WAIT, "to_wait");
    mc(0, E_ERR, "to_release");
    idle(E_ERR, "err_sticky");
    step(1, 1, 9, 0, 9, 0, 1, 0, 0, 0, E_LU | E_ERR, "lu_with_err");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE, "reset_clears_err");

    // Done on the 8th wait cycle: no error.
    mc(0, E_START, "tod_start");
    repeat (7) mc(0, E_WAIT, "tod_wait");
    mc(1, E_WAIT, "tod_done_8th");
    mc(0, E_IDLE, "tod_release");
    idle(E_IDLE, "tod_no_err");

    // Reset in the middle of MC_WAIT.
    mc(0, E_START, "rmw_start");
    repeat (2) mc(0, E_WAIT, "rmw_wait");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_IDLE, "rmw_reset");
    idle(E_IDLE, "rmw_run_no_start");
    mc(0, E_START, "rmw_restart");
    mc(1, E_WAIT, "rmw_wait_done");
    mc(0, E_IDLE, "rmw_release");
    idle(E_IDLE, "rmw_idle");

`ifdef HAZARD_PERF_CNT_EN
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE, "perf_reset");
    repeat (5) step(1, 1, 5, 0, 5, 0, 1, 0, 0, 0, E_LU, "perf_lu");
    idle(E_IDLE, "perf_idle");
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 2'd3) begin
      n_errors++;
      $display("FAIL stall_cnt_sat: got %0d expected 3", stall_cnt);
    end
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR, "perf_br");
    idle(E_IDLE, "perf_idle2");
    @(negedge clk);
    n_checks++;
    if (flush_cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL flush_cnt: got %0d expected 1", flush_cnt);
    end
`endif

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
